accel_avg_filter: RTL

Downstream consumer of the accelerometer sample word produced by the MPU9250 I2C driver. It averages each new signed 16-bit sample with the preceding ones using a power-of-two-depth moving average (boxcar). The average is then passed to the control and telemetry logic.
- Circular sample buffer with a running sum.
- Fill tracking, so no output is produced until the window is full.
- Synchronous flush input.

---
 rtl/accel_avg_filter.sv | 118 +++++++++++
 1 files changed

// File: rtl/accel_avg_filter.sv
// Power-of-two boxcar average of signed accelerometer samples, using a circular buffer and a running sum.
// Define ACCEL_THRESH_EN to add the thresh input and the over_thresh |avg| limit flag.
module accel_avg_filter #(
  parameter int LOG2_DEPTH = 3,
  parameter int DATA_W     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   sample_in,
  input  logic                sample_valid,
  input  logic                flush,
`ifdef ACCEL_THRESH_EN
  input  logic [DATA_W-1:0]   thresh,
  output logic                over_thresh,
`endif
  output logic [DATA_W-1:0]   avg_out,
  output logic                avg_valid,
  output logic                window_full,
  output logic [LOG2_DEPTH:0] fill_cnt
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int SUM_W = DATA_W + LOG2_DEPTH;
  localparam logic [LOG2_DEPTH:0] FULL_CNT = (LOG2_DEPTH + 1)'(DEPTH);

  typedef enum logic {FILL, RUN} state_t;

  state_t                   state, state_nxt;
  logic [DATA_W-1:0]        buf_mem [DEPTH];
  logic [LOG2_DEPTH-1:0]    wr_ptr, wr_ptr_nxt;
  logic signed [SUM_W-1:0]  sum, sum_nxt;
  logic signed [SUM_W-1:0]  sample_ext, old_ext;
  logic [LOG2_DEPTH:0]      fill_nxt;
  logic                     pending, pending_nxt;
  logic [DATA_W-1:0]        avg_nxt;
  logic                     accept;

  assign accept      = sample_valid && !flush;
  assign sample_ext  = SUM_W'($signed(sample_in));
  assign old_ext     = SUM_W'($signed(buf_mem[wr_ptr]));
  assign avg_nxt     = DATA_W'(sum >>> LOG2_DEPTH);
  assign window_full = (state == RUN);

  // Next-state logic; pending marks that the following edge must publish a new average.
  always_comb begin
    state_nxt   = state;
    sum_nxt     = sum;
    fill_nxt    = fill_cnt;
    wr_ptr_nxt  = wr_ptr;
    pending_nxt = 1'b0;
    if (flush) begin
      state_nxt  = FILL;
      sum_nxt    = '0;
      fill_nxt   = '0;
      wr_ptr_nxt = '0;
    end else if (sample_valid) begin
      wr_ptr_nxt = wr_ptr + 1'b1;
      case (state)
        FILL: begin
          sum_nxt  = sum + sample_ext;
          fill_nxt = fill_cnt + 1'b1;
          if (fill_nxt == FULL_CNT) begin
            state_nxt   = RUN;
            pending_nxt = 1'b1;
          end
        end
        RUN: begin
          sum_nxt     = sum + sample_ext - old_ext;
          pending_nxt = 1'b1;
        end
        default: state_nxt = FILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      sum       <= '0;
      fill_cnt  <= '0;
      wr_ptr    <= '0;
      pending   <= 1'b0;
      avg_out   <= '0;
      avg_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      sum       <= sum_nxt;
      fill_cnt  <= fill_nxt;
      wr_ptr    <= wr_ptr_nxt;
      pending   <= pending_nxt;
      avg_valid <= pending && !flush;
      if (pending && !flush)
        avg_out <= avg_nxt;
    end
  end

  // The buffer is not reset; the FILL state never reads it, so stale contents cannot leak into the sum.
  always_ff @(posedge clk) begin
    if (accept && !rst)
      buf_mem[wr_ptr] <= sample_in;
  end

`ifdef ACCEL_THRESH_EN
  logic signed [DATA_W:0] avg_wide, avg_abs;

  // The magnitude uses one extra bit so that the most negative sample has a representable absolute value.
  assign avg_wide = (DATA_W + 1)'($signed(avg_nxt));
  assign avg_abs  = avg_wide[DATA_W] ? -avg_wide : avg_wide;

  always_ff @(posedge clk) begin
    if (rst || flush)
      over_thresh <= 1'b0;
    else if (pending)
      over_thresh <= (avg_abs > (DATA_W + 1)'($signed(thresh)));
  end
`endif

endmodule
